eth_tx_arb: RTL and testbench

- Two-requester, packet-granular round-robin arbiter in front of the single packet_tx MAC transmitter.
- Lets two frame sources, e.g. the receive-loopback path and a locally generated responder, share one RMII TX port.
- Selects a requester, forwards its header through the header_valid/header_rd handshake, then passes its AXI-Stream payload until tlast.
- Also enforces a maximum payload length, truncating and draining overlong frames.

---
 rtl/eth_pkg.sv | 34 +++
 rtl/eth_tx_arb_if.sv | 44 ++++
 rtl/rr_arb2.sv | 32 +++
 rtl/eth_tx_arb.sv | 124 ++++++++++++
 tb/tb_eth_tx_arb.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared types, widths and the 2-way round-robin pick helper
//                for the Ethernet TX arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package eth_pkg;

   localparam int HDR_W = 112;

   typedef struct packed {
      logic [47:0] src_mac;
      logic [47:0] dest_mac;
      logic [15:0] ethertype;
   } eth_hdr_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HDR   = 2'd1,
      DATA  = 2'd2,
      DRAIN = 2'd3
   } arb_state_t;

   // prio=0 lets port 0 win a tie, prio=1 lets port 1 win.
   function automatic logic [1:0] rr_pick2(input logic [1:0] req, input logic prio);
      if (req == 2'b11) begin
         return prio ? 2'b10 : 2'b01;
      end
      return req;
   endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : eth_tx_arb_if
//  Description : Requester-side header/AXI-Stream bundle and packet_tx-side
//                header/AXI-Stream bundle of the TX arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface eth_tx_arb_if;
   import eth_pkg::*;

   logic [HDR_W-1:0] s_header       [0:1];
   logic             s_header_valid [0:1];
   logic             s_header_rd    [0:1];
   logic [7:0]       s_axis_tdata   [0:1];
   logic             s_axis_tvalid  [0:1];
   logic             s_axis_tlast   [0:1];
   logic             s_axis_tready  [0:1];

   logic [HDR_W-1:0] m_header;
   logic             m_header_valid;
   logic             m_header_rd;
   logic [7:0]       m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tlast;
   logic             m_axis_tready;

   // The arbiter itself.
   modport master (
      input  s_header, s_header_valid, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      input  m_header_rd, m_axis_tready,
      output s_header_rd, s_axis_tready,
      output m_header, m_header_valid, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );

   // Requesters plus packet_tx, seen from outside the arbiter.
   modport slave (
      output s_header, s_header_valid, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      output m_header_rd, m_axis_tready,
      input  s_header_rd, s_axis_tready,
      input  m_header, m_header_valid, m_axis_tdata, m_axis_tvalid, m_axis_tlast
   );

endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Combinational 2-way round-robin pick; the priority pointer
//                moves to the other port when a frame completes.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
   import eth_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_done,
   input  logic       i_done_idx,
   output logic [1:0] o_pick
);

   logic r_prio;

   assign o_pick = rr_pick2(i_req, r_prio);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_prio <= 1'b0;
      end else if (i_done) begin
         r_prio <= ~i_done_idx;
      end
   end

endmodule
`default_nettype wire

// File: rtl/eth_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : eth_tx_arb
//  Description : Packet-granular round-robin arbiter sharing one packet_tx
//                between two frame sources, with payload length truncation.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_arb
   import eth_pkg::*;
#(
   parameter int MAX_BEATS = 1500,
   parameter int CNT_W     = 11
) (
   input  logic                clk,
   input  logic                rst_n,
   eth_tx_arb_if.master        bus,
   output logic [1:0]          grant,
   output logic                trunc
);

   localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BEATS - 1);

   arb_state_t       r_state;
   logic [1:0]       r_grant;
   logic [CNT_W-1:0] r_cnt;

   logic       w_g;
   logic [1:0] w_req;
   logic [1:0] w_pick;
   logic       w_hv;
   logic       w_tv;
   logic       w_tl;
   logic [7:0] w_td;
   logic       w_hs;
   logic       w_at_max;
   logic       w_drain_last;
   logic       w_done;

   assign w_g   = r_grant[1];
   assign w_req = {bus.s_header_valid[1], bus.s_header_valid[0]};
   assign w_hv  = bus.s_header_valid[w_g];
   assign w_tv  = bus.s_axis_tvalid[w_g];
   assign w_tl  = bus.s_axis_tlast[w_g];
   assign w_td  = bus.s_axis_tdata[w_g];

   assign w_hs         = (r_state == DATA) && w_tv && bus.m_axis_tready;
   assign w_at_max     = (r_cnt == c_last_beat);
   assign w_drain_last = (r_state == DRAIN) && w_tv && w_tl;
   assign w_done       = rst_n && ((w_hs && w_tl) || w_drain_last);

   rr_arb2 u_rr (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req      (w_req),
      .i_done     (w_done),
      .i_done_idx (w_g),
      .o_pick     (w_pick)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_grant <= 2'b00;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|w_req) begin
                  r_grant <= w_pick;
                  r_state <= HDR;
               end
            end
            HDR: begin
               if (bus.m_header_rd && w_hv) begin
                  r_cnt   <= '0;
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_hs) begin
                  r_cnt <= r_cnt + 1'b1;
                  // Source tlast takes precedence, so a frame of exactly MAX_BEATS ends cleanly.
                  if (w_tl) begin
                     r_state <= IDLE;
                     r_grant <= 2'b00;
                  end else if (w_at_max) begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (w_drain_last) begin
                  r_state <= IDLE;
                  r_grant <= 2'b00;
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= 2'b00;
            end
         endcase
      end
   end

   // Outputs are masked while rst_n is low so an aborted frame never pops or accepts.
   assign bus.m_header       = (rst_n && r_state == HDR) ? bus.s_header[w_g] : '0;
   assign bus.m_header_valid = rst_n && (r_state == HDR) && w_hv;
   assign bus.m_axis_tdata   = (rst_n && r_state == DATA) ? w_td : 8'h00;
   assign bus.m_axis_tvalid  = rst_n && (r_state == DATA) && w_tv;
   assign bus.m_axis_tlast   = rst_n && (r_state == DATA) && (w_tl || w_at_max);

   assign grant = r_grant;
   assign trunc = rst_n && w_hs && !w_tl && w_at_max;

   for (genvar i = 0; i < 2; i++) begin : g_port
      assign bus.s_header_rd[i]   = rst_n && r_grant[i] && (r_state == HDR) &&
                                    w_hv && bus.m_header_rd;
      assign bus.s_axis_tready[i] = rst_n && r_grant[i] &&
                                    (((r_state == DATA) && bus.m_axis_tready) ||
                                     (r_state == DRAIN));
   end

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_tx_arb
//  Description : Self-checking bench for eth_tx_arb (MAX_BEATS=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_tx_arb;
   import eth_pkg::*;

   localparam int MAX_B = 8;
   localparam logic [HDR_W-1:0] c_hdr = 112'h0102_0304_0506_A1A2_A3A4_A5A6_0800;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] grant;
   logic       trunc;

   eth_tx_arb_if bus ();

   eth_tx_arb #(.MAX_BEATS(MAX_B), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master),
      .grant (grant),
      .trunc (trunc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        hv;
      logic        mrd;
      logic        tv;
      logic [7:0]  td;
      logic        tl;
      logic        mrdy;
      logic [17:0] want;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   logic [HDR_W-1:0] hq [2][$];
   logic [8:0]       pq [2][$];
   logic [HDR_W-1:0] hdr_out [$];
   logic [7:0]       byte_out [$];
   bit               last_out [$];
   logic [7:0]       exp_bytes [$];
   bit               exp_last [$];
   logic             pop_h [2];
   logic             pop_d [2];
   int  order_err, nongrant_err, mirror_err, drain_cyc, trunc_cnt;
   bit  in_frame, toggle;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic hv, mrd, tv, input logic [7:0] td,
                               input logic tl, mrdy, input logic [1:0] g,
                               input logic hr0, mhv, mtv, input logic [7:0] mtd,
                               input logic mtl, tr0);
      vec_t v;
      v.hv = hv; v.mrd = mrd; v.tv = tv; v.td = td; v.tl = tl; v.mrdy = mrdy;
      v.want = {g, hr0, 1'b0, mhv, mtv, mtd, mtl, tr0, 1'b0, 1'b0};
      return v;
   endfunction

   function automatic logic [17:0] outv();
      return {grant, bus.s_header_rd[0], bus.s_header_rd[1], bus.m_header_valid,
              bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast,
              bus.s_axis_tready[0], bus.s_axis_tready[1], trunc};
   endfunction

   function automatic logic [HDR_W-1:0] mkhdr(input int p, input int k);
      eth_hdr_t h;
      h.src_mac   = 48'(p);
      h.dest_mac  = 48'(k) + 48'h100;
      h.ethertype = 16'h88B5;
      return h;
   endfunction

   function automatic int count_bad();
      int bad = 0;
      for (int i = 0; i < exp_bytes.size(); i++) begin
         if (i >= byte_out.size()) bad++;
         else if (byte_out[i] !== exp_bytes[i] || last_out[i] != exp_last[i]) bad++;
      end
      return bad;
   endfunction

   task automatic drive();
      logic [8:0] e;
      for (int p = 0; p < 2; p++) begin
         bus.s_header_valid[p] = (hq[p].size() != 0);
         bus.s_header[p]       = (hq[p].size() != 0) ? hq[p][0] : '0;
         e = (pq[p].size() != 0) ? pq[p][0] : 9'h000;
         bus.s_axis_tvalid[p]  = (pq[p].size() != 0);
         bus.s_axis_tdata[p]   = e[7:0];
         bus.s_axis_tlast[p]   = e[8];
      end
   endtask

   task automatic clear_model();
      for (int p = 0; p < 2; p++) begin
         hq[p].delete();
         pq[p].delete();
         pop_h[p] = 1'b0;
         pop_d[p] = 1'b0;
      end
      hdr_out.delete(); byte_out.delete(); last_out.delete();
      exp_bytes.delete(); exp_last.delete();
      order_err = 0; nongrant_err = 0; mirror_err = 0; drain_cyc = 0; trunc_cnt = 0;
      in_frame = 1'b0; toggle = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_model();
      drive();
      bus.m_header_rd   = 1'b0;
      bus.m_axis_tready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic observe();
      for (int p = 0; p < 2; p++) begin
         pop_h[p] = bus.s_header_rd[p];
         pop_d[p] = bus.s_axis_tvalid[p] && bus.s_axis_tready[p];
         if (!grant[p] && (bus.s_axis_tready[p] || bus.s_header_rd[p])) nongrant_err++;
         if (grant[p] && bus.m_axis_tvalid && (bus.s_axis_tready[p] != bus.m_axis_tready))
            mirror_err++;
         if (bus.s_axis_tready[p] && bus.s_axis_tvalid[p] && !bus.m_axis_tvalid) drain_cyc++;
      end
      if (bus.m_header_valid && bus.m_header_rd) begin
         hdr_out.push_back(bus.m_header);
         if (in_frame) order_err++;
         in_frame = 1'b1;
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
         byte_out.push_back(bus.m_axis_tdata);
         last_out.push_back(bus.m_axis_tlast);
         if (bus.m_axis_tlast) in_frame = 1'b0;
      end
      if (trunc) trunc_cnt++;
   endtask

   task automatic cycle();
      @(negedge clk);
      observe();
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
         if (pop_h[p]) void'(hq[p].pop_front());
         if (pop_d[p]) void'(pq[p].pop_front());
      end
      if (toggle) bus.m_axis_tready = ~bus.m_axis_tready;
      drive();
   endtask

   task automatic run_until_done(input string name, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         cycle();
         if (hq[0].size() == 0 && hq[1].size() == 0 && pq[0].size() == 0 &&
             pq[1].size() == 0 && grant == 2'b00) ok = 1'b1;
      end
      chk({name, "_done"}, 128'(ok), 128'(1));
   endtask

   task automatic push_frame(input int p, input logic [HDR_W-1:0] h,
                             input logic [7:0] base, input int len);
      hq[p].push_back(h);
      for (int j = 0; j < len; j++) pq[p].push_back({j == len - 1, base + 8'(j)});
   endtask

   initial begin
      vec_t vecs [10];
      vecs[0] = mk(1, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 0);
      vecs[1] = mk(1, 0, 0, 8'h00, 0, 1, 2'b01, 0, 1, 0, 8'h00, 0, 0);
      vecs[2] = vecs[1];
      vecs[3] = vecs[1];
      vecs[4] = mk(1, 1, 0, 8'h00, 0, 1, 2'b01, 1, 1, 0, 8'h00, 0, 0);
      vecs[5] = mk(0, 0, 1, 8'h11, 0, 1, 2'b01, 0, 0, 1, 8'h11, 0, 1);
      vecs[6] = mk(0, 0, 1, 8'h22, 0, 1, 2'b01, 0, 0, 1, 8'h22, 0, 1);
      vecs[7] = mk(0, 0, 1, 8'h33, 0, 1, 2'b01, 0, 0, 1, 8'h33, 0, 1);
      vecs[8] = mk(0, 0, 1, 8'h44, 1, 1, 2'b01, 0, 0, 1, 8'h44, 1, 1);
      vecs[9] = mk(0, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0, 8'h00, 0, 0);

      // Reset state, then the single port-0 frame with a 3-cycle header delay.
      do_reset();
      @(negedge clk);
      chk("reset_state", 128'(outv()), 128'(0));
      chk("reset_hdr", 128'(bus.m_header), 128'(0));
      @(posedge clk);
      #1;
      bus.s_header[0] = c_hdr;
      for (int i = 0; i < 10; i++) begin
         bus.s_header_valid[0] = vecs[i].hv;
         bus.m_header_rd       = vecs[i].mrd;
         bus.s_axis_tvalid[0]  = vecs[i].tv;
         bus.s_axis_tdata[0]   = vecs[i].td;
         bus.s_axis_tlast[0]   = vecs[i].tl;
         bus.m_axis_tready     = vecs[i].mrdy;
         @(negedge clk);
         chk($sformatf("vec%0d", i), 128'(outv()), 128'(vecs[i].want));
         if (i == 1) chk("hdr_fwd", 128'(bus.m_header), 128'(c_hdr));
         @(posedge clk);
         #1;
      end

      // Both ports requesting continuously: strict alternation.
      do_reset();
      bus.m_header_rd   = 1'b1;
      bus.m_axis_tready = 1'b1;
      for (int k = 0; k < 3; k++)
         for (int p = 0; p < 2; p++) push_frame(p, mkhdr(p, k), 8'(p * 64 + k * 8), 3);
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 3; j++) begin
            exp_bytes.push_back(8'((i % 2) * 64 + (i / 2) * 8 + j));
            exp_last.push_back(j == 2);
         end
      drive();
      run_until_done("rr", 200);
      for (int i = 0; i < 6; i++)
         chk($sformatf("rr_order%0d", i),
             128'((i < hdr_out.size()) ? hdr_out[i] : '0), 128'(mkhdr(i % 2, i / 2)));
      chk("rr_len", 128'(byte_out.size()), 128'(18));
      chk("rr_bytes_bad", 128'(count_bad()), 128'(0));
      chk("rr_overlap", 128'(order_err), 128'(0));
      chk("rr_nongrant", 128'(nongrant_err), 128'(0));

      // Toggling m_axis_tready during a 6-byte frame.
      do_reset();
      bus.m_header_rd   = 1'b1;
      bus.m_axis_tready = 1'b1;
      toggle            = 1'b1;
      push_frame(0, c_hdr, 8'hA0, 6);
      for (int j = 0; j < 6; j++) begin
         exp_bytes.push_back(8'hA0 + 8'(j));
         exp_last.push_back(j == 5);
      end
      drive();
      run_until_done("tog", 80);
      chk("tog_len", 128'(byte_out.size()), 128'(6));
      chk("tog_bytes_bad", 128'(count_bad()), 128'(0));
      chk("tog_mirror", 128'(mirror_err), 128'(0));

      // Port 1 overlong frame: 12 bytes truncated to 8, 4 drained.
      do_reset();
      bus.m_header_rd   = 1'b1;
      bus.m_axis_tready = 1'b1;
      push_frame(1, mkhdr(1, 7), 8'hB0, 12);
      for (int j = 0; j < MAX_B; j++) begin
         exp_bytes.push_back(8'hB0 + 8'(j));
         exp_last.push_back(j == MAX_B - 1);
      end
      drive();
      run_until_done("trn", 80);
      chk("trn_len", 128'(byte_out.size()), 128'(MAX_B));
      chk("trn_bytes_bad", 128'(count_bad()), 128'(0));
      chk("trn_pulses", 128'(trunc_cnt), 128'(1));
      chk("trn_drain", 128'(drain_cyc), 128'(4));
      chk("trn_src_empty", 128'(pq[1].size()), 128'(0));

      // Exactly MAX_BEATS bytes with source tlast on the last one.
      do_reset();
      bus.m_header_rd   = 1'b1;
      bus.m_axis_tready = 1'b1;
      push_frame(0, c_hdr, 8'hC0, MAX_B);
      for (int j = 0; j < MAX_B; j++) begin
         exp_bytes.push_back(8'hC0 + 8'(j));
         exp_last.push_back(j == MAX_B - 1);
      end
      drive();
      run_until_done("exa", 80);
      chk("exa_len", 128'(byte_out.size()), 128'(MAX_B));
      chk("exa_bytes_bad", 128'(count_bad()), 128'(0));
      chk("exa_trunc", 128'(trunc_cnt), 128'(0));
      chk("exa_drain", 128'(drain_cyc), 128'(0));

      // Port 0 finishes (pointer moves to 1), port 1 is reset mid-DATA.
      do_reset();
      bus.m_header_rd   = 1'b1;
      bus.m_axis_tready = 1'b1;
      push_frame(0, mkhdr(0, 9), 8'hE0, 1);
      push_frame(1, mkhdr(1, 9), 8'hD0, 6);
      drive();
      for (int i = 0; i < 40 && byte_out.size() < 3; i++) cycle();
      chk("rst_reach_data", 128'(byte_out.size()), 128'(3));
      chk("rst_owner", 128'(grant), 128'(2'b10));
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_no_ready", 128'({bus.s_axis_tready[0], bus.s_axis_tready[1],
                                bus.s_header_rd[0], bus.s_header_rd[1]}), 128'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_model();
      drive();
      @(negedge clk);
      chk("rst_after", 128'({outv(), bus.m_header}), 128'(0));
      @(posedge clk);
      #1;
      push_frame(0, mkhdr(0, 10), 8'hF0, 1);
      push_frame(1, mkhdr(1, 10), 8'hF8, 1);
      drive();
      @(posedge clk);
      #1;
      chk("rst_tie_grant", 128'(grant), 128'(2'b01));
      run_until_done("rst_tail", 50);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
